// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data load/store.
// Optional transaction timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TO_CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  output logic        i_read_valid,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  output logic        d_read_valid,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  output logic        d_write_finish,
  output logic [31:0] rdata_out,
  output logic        m_read_req,
  output logic        m_write_req,
  output logic        m_w,
  output logic        m_hw,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic        m_read_valid,
  input  logic [31:0] m_read_data,
  input  logic        m_write_finish,
  output logic        bus_error
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, IRD, DRD, DWR} state_e;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_e;

  state_e        state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic          m_read_req_q, m_read_req_d;
  logic          m_write_req_q, m_write_req_d;
  logic          m_w_q, m_w_d;
  logic          m_hw_q, m_hw_d;
  logic [DW-1:0] m_adr_q, m_adr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic done_c;
  logic timeout_c;
  logic end_c;
  logic rd_busy_c;
  logic grant_data_c;

  // Completion only counts when it matches the transaction type in flight.
  always_comb begin
    done_c = 1'b0;
    case (state_q)
      IRD, DRD: done_c = m_read_valid;
      DWR:      done_c = m_write_finish;
      default:  done_c = 1'b0;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) to_cnt_d = '0;
    else                 to_cnt_d = to_cnt_q + TO_CNT_W'(1);
  end

  // Counter is zero in the first busy cycle, so the abort lands in busy cycle TIMEOUT_CYCLES.
  assign timeout_c = (state_q != IDLE) && !done_c &&
                     (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic cfg_unused;
  assign cfg_unused = (64'(TIMEOUT_CYCLES) < (64'd1 << TO_CNT_W));
  assign timeout_c  = 1'b0;
`endif

  assign end_c     = done_c | timeout_c;
  assign rd_busy_c = (state_q == IRD) || (state_q == DRD);

  // Data class wins when instruction is idle or instruction was served last.
  assign grant_data_c = (d_write_req || d_read_req) &&
                        (!i_read_req || (last_grant_q == GRANT_INSTR));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    m_read_req_d  = m_read_req_q;
    m_write_req_d = m_write_req_q;
    m_w_d         = m_w_q;
    m_hw_d        = m_hw_q;
    m_adr_d       = m_adr_q;
    m_wdata_d     = m_wdata_q;
    rdata_d       = rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data_c) begin
          last_grant_d = GRANT_DATA;
          if (d_write_req) begin
            state_d       = DWR;
            m_write_req_d = 1'b1;
            m_w_d         = d_write_w;
            m_hw_d        = d_write_hw;
            m_adr_d       = d_write_adr;
            m_wdata_d     = d_write_data;
          end else begin
            state_d      = DRD;
            m_read_req_d = 1'b1;
            m_w_d        = d_read_w;
            m_hw_d       = d_read_hw;
            m_adr_d      = d_read_adr;
          end
        end else if (i_read_req) begin
          last_grant_d = GRANT_INSTR;
          state_d      = IRD;
          m_read_req_d = 1'b1;
          m_w_d        = i_read_w;
          m_hw_d       = i_read_hw;
          m_adr_d      = i_read_adr;
        end
      end
      default: begin
        if (end_c) begin
          state_d       = IDLE;
          m_read_req_d  = 1'b0;
          m_write_req_d = 1'b0;
        end
      end
    endcase

    if (rd_busy_c) rdata_d = m_read_data;
    if (timeout_c) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_INSTR;
      m_read_req_q  <= 1'b0;
      m_write_req_q <= 1'b0;
      m_w_q         <= 1'b0;
      m_hw_q        <= 1'b0;
      m_adr_q       <= '0;
      m_wdata_q     <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      m_read_req_q  <= m_read_req_d;
      m_write_req_q <= m_write_req_d;
      m_w_q         <= m_w_d;
      m_hw_q        <= m_hw_d;
      m_adr_q       <= m_adr_d;
      m_wdata_q     <= m_wdata_d;
      rdata_q       <= rdata_d;
    end
  end

  // Completion pulses are combinational so the requester can drop its req at the same edge.
  assign i_read_valid   = rst_n && (state_q == IRD) && end_c;
  assign d_read_valid   = rst_n && (state_q == DRD) && end_c;
  assign d_write_finish = rst_n && (state_q == DWR) && end_c;
  assign bus_error      = rst_n && timeout_c;

  assign rdata_out   = timeout_c ? '0 : (rd_busy_c ? m_read_data : rdata_q);
  assign m_read_req  = m_read_req_q;
  assign m_write_req = m_write_req_q;
  assign m_w         = m_w_q;
  assign m_hw        = m_hw_q;
  assign m_adr       = m_adr_q;
  assign m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected grants and read data are queued when
// stimulus is driven and popped when the arbiter issues a bus request or completion.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
  localparam int unsigned TO_W   = 4;
`else
  localparam int unsigned TO_CYC = 1023;
  localparam int unsigned TO_W   = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read_req = 1'b0, i_read_w = 1'b0, i_read_hw = 1'b0;
  logic [31:0] i_read_adr = '0;
  logic        i_read_valid;
  logic        d_read_req = 1'b0, d_read_w = 1'b0, d_read_hw = 1'b0;
  logic [31:0] d_read_adr = '0;
  logic        d_read_valid;
  logic        d_write_req = 1'b0, d_write_w = 1'b0, d_write_hw = 1'b0;
  logic [31:0] d_write_adr = '0, d_write_data = '0;
  logic        d_write_finish;
  logic [31:0] rdata_out;
  logic        m_read_req, m_write_req, m_w, m_hw;
  logic [31:0] m_adr, m_wdata;
  logic        m_read_valid = 1'b0;
  logic [31:0] m_read_data = '0;
  logic        m_write_finish = 1'b0;
  logic        bus_error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_q[$];
  logic [31:0] rd_q[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_CNT_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw),
    .i_read_adr(i_read_adr), .i_read_valid(i_read_valid),
    .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw),
    .d_read_adr(d_read_adr), .d_read_valid(d_read_valid),
    .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .d_write_finish(d_write_finish), .rdata_out(rdata_out),
    .m_read_req(m_read_req), .m_write_req(m_write_req), .m_w(m_w), .m_hw(m_hw),
    .m_adr(m_adr), .m_wdata(m_wdata),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data),
    .m_write_finish(m_write_finish), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_read_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;
    m_read_valid = 1'b0; m_write_finish = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the next bus request and checks it against the scoreboard head.
  task automatic wait_grant(input string name, output int lat);
    grant_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(m_read_req || m_write_req) && lat < 20);
    tests++;
    if (!(m_read_req || m_write_req)) begin
      fails++;
      $display("FAIL %s_grant: no bus request after %0d cycles, required one", name, lat);
      return;
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_grant: unexpected request adr=%h, required none", name, m_adr);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    if ({m_write_req, m_read_req} !== {e.wr, ~e.wr}) begin
      fails++;
      $display("FAIL %s_kind: got wr=%b rd=%b required wr=%b", name, m_write_req, m_read_req, e.wr);
    end
    tests++;
    if (m_adr !== e.adr) begin
      fails++;
      $display("FAIL %s_adr: got %h required %h", name, m_adr, e.adr);
    end
    if (e.wr) begin
      tests++;
      if (m_wdata !== e.wdata) begin
        fails++;
        $display("FAIL %s_wdata: got %h required %h", name, m_wdata, e.wdata);
      end
    end
  endtask

  // Memory answers in busy cycle lat; who: 0 fetch, 1 load, 2 store.
  task automatic respond(input string name, input int lat, input int who,
                         input logic [31:0] rd, input bit keep);
    logic [2:0]  exp_v, got_v;
    logic [31:0] exp_rd;
    bit          held;
    held = 1'b1;
    for (int k = 1; k < lat; k++) begin
      if (!(m_read_req || m_write_req)) held = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!held || !(m_read_req || m_write_req)) begin
      fails++;
      $display("FAIL %s_hold: request dropped before completion, required held", name);
    end
    if (who == 2) begin
      m_write_finish = 1'b1;
    end else begin
      m_read_valid = 1'b1;
      m_read_data  = rd;
      rd_q.push_back(rd);
    end
    #1;
    exp_v = 3'(1 << who);
    got_v = {d_write_finish, d_read_valid, i_read_valid};
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s_pulse: got {wf,dv,iv}=%b required %b", name, got_v, exp_v);
    end
    if (who != 2) begin
      exp_rd = rd_q.pop_front();
      tests++;
      if (rdata_out !== exp_rd) begin
        fails++;
        $display("FAIL %s_rdata: got %h required %h", name, rdata_out, exp_rd);
      end
    end
    tests++;
    if (bus_error !== 1'b0) begin
      fails++;
      $display("FAIL %s_bus_error: got %b required 0", name, bus_error);
    end
    @(negedge clk);
    m_read_valid = 1'b0;
    m_write_finish = 1'b0;
    if (!keep) begin
      case (who)
        0:       i_read_req = 1'b0;
        1:       d_read_req = 1'b0;
        default: d_write_req = 1'b0;
      endcase
    end
    tests++;
    if ({m_read_req, m_write_req} !== 2'b00) begin
      fails++;
      $display("FAIL %s_release: got rd=%b wr=%b required both 0", name, m_read_req, m_write_req);
    end
    if (who != 2) begin
      tests++;
      if (rdata_out !== rd) begin
        fails++;
        $display("FAIL %s_rdata_hold: got %h required %h", name, rdata_out, rd);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({m_read_req, m_write_req, m_w, m_hw, i_read_valid, d_read_valid, d_write_finish, bus_error} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 00000000", {m_read_req, m_write_req, m_w, m_hw,
               i_read_valid, d_read_valid, d_write_finish, bus_error});
    end
    tests++;
    if ({m_adr, m_wdata, rdata_out} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data: got adr=%h wdata=%h rdata=%h required all 0", m_adr, m_wdata, rdata_out);
    end
  endtask

  task automatic test_fetch();
    int lat;
    i_read_req = 1'b1; i_read_w = 1'b1; i_read_hw = 1'b0; i_read_adr = 32'h0000_0100;
    exp_q.push_back('{1'b0, 32'h0000_0100, 32'h0});
    wait_grant("fetch", lat);
    tests++;
    if (lat != 1 || m_w !== 1'b1) begin
      fails++;
      $display("FAIL fetch_latency: got lat=%0d m_w=%b required lat=1 m_w=1", lat, m_w);
    end
    respond("fetch", 3, 0, 32'h0000_0013, 1'b0);
  endtask

  task automatic test_arb_after_reset();
    int lat;
    do_reset();
    i_read_req = 1'b1; i_read_adr = 32'h0000_0104;
    d_read_req = 1'b1; d_read_adr = 32'h0000_0300; d_read_w = 1'b0; d_read_hw = 1'b1;
    exp_q.push_back('{1'b0, 32'h0000_0300, 32'h0});
    exp_q.push_back('{1'b0, 32'h0000_0104, 32'h0});
    wait_grant("arb_d", lat);
    tests++;
    if ({m_w, m_hw} !== 2'b01) begin
      fails++;
      $display("FAIL arb_d_size: got w,hw=%b required 01", {m_w, m_hw});
    end
    respond("arb_d", 2, 1, 32'hA5A5_0001, 1'b0);
    wait_grant("arb_i", lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL arb_i_latency: got %0d required 1", lat);
    end
    respond("arb_i", 2, 0, 32'h5A5A_0002, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    i_read_adr = 32'h0000_0500; d_read_adr = 32'h0000_0400; d_read_w = 1'b1; d_read_hw = 1'b0;
    i_read_req = 1'b1; d_read_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back('{1'b0, (k % 2 == 0) ? 32'h0000_0400 : 32'h0000_0500, 32'h0});
      wait_grant("b2b", lat);
      tests++;
      if (lat != 1) begin
        fails++;
        $display("FAIL b2b_spacing: txn %0d got lat=%0d required 1", k, lat);
      end
      respond("b2b", 1 + (k % 3), (k % 2 == 0) ? 1 : 0, 32'h1000_0000 + 32'(k), k < 4);
    end
  endtask

  task automatic test_write_priority();
    int lat;
    d_write_req = 1'b1; d_write_adr = 32'h0000_0200; d_write_data = 32'hDEAD_BEEF;
    d_write_w = 1'b1; d_write_hw = 1'b0;
    d_read_req = 1'b1; d_read_adr = 32'h0000_0204;
    exp_q.push_back('{1'b1, 32'h0000_0200, 32'hDEAD_BEEF});
    exp_q.push_back('{1'b0, 32'h0000_0204, 32'h0});
    wait_grant("wr", lat);
    respond("wr", 2, 2, 32'h0, 1'b0);
    wait_grant("wr_rd", lat);
    m_write_finish = 1'b1;
    #1;
    tests++;
    if ({d_write_finish, d_read_valid} !== 2'b00) begin
      fails++;
      $display("FAIL spurious_wf: got wf,dv=%b required 00", {d_write_finish, d_read_valid});
    end
    @(negedge clk);
    m_write_finish = 1'b0;
    respond("wr_rd", 1, 1, 32'hCAFE_F00D, 1'b0);
    m_read_valid = 1'b1; m_read_data = 32'h0000_0BAD;
    #1;
    tests++;
    if ({i_read_valid, d_read_valid, rdata_out} !== {2'b00, 32'hCAFE_F00D}) begin
      fails++;
      $display("FAIL spurious_idle_rv: got iv,dv=%b rdata=%h required 00 cafef00d",
               {i_read_valid, d_read_valid}, rdata_out);
    end
    @(negedge clk);
    m_read_valid = 1'b0;
  endtask

  task automatic test_reset_mid_txn();
    int lat;
    d_read_req = 1'b1; d_read_adr = 32'h0000_0600;
    exp_q.push_back('{1'b0, 32'h0000_0600, 32'h0});
    wait_grant("rst_mid", lat);
    rst_n = 1'b0; d_read_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (m_read_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_req: got %b required 0", m_read_req);
    end
    m_read_valid = 1'b1; m_read_data = 32'h7777_7777;
    #1;
    tests++;
    if ({i_read_valid, d_read_valid} !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid_late: got iv,dv=%b required 00", {i_read_valid, d_read_valid});
    end
    @(negedge clk);
    m_read_valid = 1'b0;
    tests++;
    if ({m_read_req, m_write_req} !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid_idle: got rd,wr=%b required 00", {m_read_req, m_write_req});
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    do_reset();
    i_read_req = 1'b1; i_read_adr = 32'h0000_0700; m_read_data = 32'h1234_5678;
    exp_q.push_back('{1'b0, 32'h0000_0700, 32'h0});
    wait_grant("to", lat);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if ({bus_error, i_read_valid} !== ((k == 8) ? 2'b11 : 2'b00)) begin
        fails++;
        $display("FAIL to_pulse: cycle %0d got be,iv=%b required %b", k, {bus_error, i_read_valid},
                 (k == 8) ? 2'b11 : 2'b00);
      end
    end
    tests++;
    if (rdata_out !== 32'h0) begin
      fails++;
      $display("FAIL to_rdata: got %h required 0", rdata_out);
    end
    @(negedge clk);
    i_read_req = 1'b0;
    tests++;
    if ({m_read_req, bus_error} !== 2'b00) begin
      fails++;
      $display("FAIL to_release: got req,be=%b required 00", {m_read_req, bus_error});
    end
  endtask
`else
  task automatic test_no_timeout();
    int  lat;
    bit  ok;
    i_read_req = 1'b1; i_read_adr = 32'h0000_0800;
    exp_q.push_back('{1'b0, 32'h0000_0800, 32'h0});
    wait_grant("long", lat);
    ok = 1'b1;
    repeat (1100) begin
      @(negedge clk);
      if (!m_read_req || bus_error || i_read_valid) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL long_wait: transaction aborted or completed early, required held with bus_error 0");
    end
    respond("long", 1, 0, 32'h0BAD_CAFE, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_arb_after_reset();
    test_back_to_back();
    test_write_priority();
    test_reset_mid_txn();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d grants outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
